dm_resp: RTL
============

Name: dm_resp

Overview:
- Data-memory responder: the target end of the CPU's load/store interface.
- The multi-cycle controller raises a request with address, write data, write enable and an access size. This block performs the access against an internal 1 KB array after a programmable number of wait states, then answers with a one-cycle acknowledge.
- Supports word accesses plus sign- and zero-extending byte loads and byte stores (lb/lbu/sb).
- Flags misaligned word accesses instead of corrupting memory.

Parameters:
- ADDR_W, 10, byte-address width; the array holds 2^(ADDR_W-2) 32-bit words.
- WAIT_CYC, 2, wait states between acceptance and acknowledge (0..15).

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- req, input, 1, access request; level-sensitive, sampled only in IDLE.
- we, input, 1, 1 = store, 0 = load.
- size, input, 2, 00 word; 01 byte, sign-extended on load; 10 byte, zero-extended on load; 11 treated as 00.
- addr, input, ADDR_W, byte address.
- wdata, input, 32, store data; byte stores use wdata[7:0].
- ack, output, 1, one-cycle completion pulse.
- rdata, output, 32, load result; valid in the ack cycle and held until the next ack.
- err, output, 1, misaligned word access; valid with ack, held until the next ack.
- busy, output, 1, high while an access is in flight (ACCESS or RESP).

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state = IDLE, wait counter = 0, ack = 0, rdata = 0, err = 0, busy = 0. The memory array is not cleared.
- State IDLE: on a rising edge with req = 1, latch we, size, addr and wdata, load counter = WAIT_CYC, go to ACCESS. With req = 0, stay in IDLE.
- State ACCESS:
  - counter != 0: decrement by 1, stay in ACCESS.
  - counter == 0: perform the access on this edge, go to RESP.
- State RESP: ack = 1 for exactly this cycle, then unconditionally return to IDLE.
- Latency: ack is high during the cycle following the (WAIT_CYC+1)-th edge after the accepting edge. With WAIT_CYC = 2, that is 3 edges after acceptance.
- Back-to-back accesses:
  - Earliest next acceptance is the edge that leaves RESP+1 (IDLE then accepts). Minimum spacing between accepting edges is WAIT_CYC+3.
  - The initiator must deassert req in the ack cycle. A req still high in IDLE starts a new access by design.
- Inputs outside IDLE: req, addr, wdata, we and size are ignored in ACCESS and RESP; latched copies are used.
- Word index: addr[ADDR_W-1:2]. Byte lane: addr[1:0], little-endian (lane 0 = bits 7:0, lane 3 = bits 31:24).
- Word load: rdata = mem[index].
- Byte loads: b = selected lane.
  - size 01: rdata = {{24{b[7]}}, b}.
  - size 10: rdata = {24'b0, b}.
- Word store: mem[index] = wdata.
- Byte store: only the selected lane is replaced with wdata[7:0]; the other three lanes keep their values (read-modify-write inside the access edge).
- Misaligned access: size 00/11 with addr[1:0] != 0.
  - No memory write; rdata = 0; err = 1; ack still pulses with normal latency.
  - Byte accesses are never misaligned.
- rdata/err on stores: rdata and err update on every completed access. For an aligned store, rdata = the word value after the write and err = 0.
- Reset mid-operation: memory is written only on the ACCESS->RESP edge.
  - Reset asserted before that edge: memory unchanged, no ack.
  - Reset asserted during RESP: ack drops immediately; the write has already committed.
- busy: equals (state != IDLE).

Test Plan:
1. WAIT_CYC = 2. Word store addr 0x010, data 0xDEADBEEF, then word load 0x010 -> ack exactly 3 edges after each acceptance; load rdata = 0xDEADBEEF, err = 0.
2. After test 1, byte store 0x55 at addr 0x012, then word load 0x010 -> rdata = 0xDE55BEEF.
3. Word store 0x00000080 at 0x020. Byte load size 01 from 0x020 -> 0xFFFFFF80. Byte load size 10 from 0x020 -> 0x00000080.
4. Word store 0x11111111 at 0x031 (misaligned) -> ack with err = 1, rdata = 0. A word load of 0x030 returns its prior contents.
5. Word store 0xA5A5A5A5 to 0x040 with rst pulsed during ACCESS (counter = 1):
   - ack, busy and rdata are 0 immediately.
   - A subsequent word load of 0x040 returns the prior contents.
6. req held high for 12 cycles with WAIT_CYC = 0 -> ack pulses every 3 cycles, each pulse one cycle wide, and busy low exactly one cycle between accesses.

Source files
------------

// File: rtl/dm_resp.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYC cycles, performs the
// access on a 32-bit word array, then pulses ack for one cycle with rdata/err.
module dm_resp #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              busy
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_next;
    logic [3:0]        count, count_next;
    logic              we_lat;
    logic [1:0]        size_lat;
    logic [ADDR_W-1:0] addr_lat;
    logic [31:0]       wdata_lat;

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        lane;
    logic              is_word;
    logic              misaligned;
    logic              do_access;
    logic [31:0]       cur_word;
    logic [31:0]       new_word;
    logic [7:0]        sel_byte;
    logic [31:0]       resp_word;

    assign word_idx   = addr_lat[ADDR_W-1:2];
    assign lane       = addr_lat[1:0];
    assign is_word    = (size_lat == 2'b00) || (size_lat == 2'b11);
    assign misaligned = is_word && (lane != 2'b00);
    assign do_access  = (state == ACCESS) && (count == 4'd0);
    assign cur_word   = mem[word_idx];
    assign sel_byte   = cur_word[{lane, 3'b000} +: 8];

    // Store merge: word stores replace every lane, byte stores only the addressed lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign new_word[gi*8 +: 8] =
                is_word                ? wdata_lat[gi*8 +: 8] :
                (lane == 2'(gi))       ? wdata_lat[7:0]       :
                                         cur_word[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        resp_word = cur_word;
        if (misaligned) begin
            resp_word = 32'd0;
        end else if (we_lat) begin
            resp_word = new_word;
        end else begin
            case (size_lat)
                2'b01:   resp_word = {{24{sel_byte[7]}}, sel_byte};
                2'b10:   resp_word = {24'd0, sel_byte};
                default: resp_word = cur_word;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = ACCESS;
                    count_next = 4'(WAIT_CYC);
                end
            end
            ACCESS: begin
                if (count != 4'd0) count_next = count - 4'd1;
                else               state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 4'd0;
            we_lat    <= 1'b0;
            size_lat  <= 2'b00;
            addr_lat  <= '0;
            wdata_lat <= 32'd0;
            rdata     <= 32'd0;
            err       <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (state == IDLE && req) begin
                we_lat    <= we;
                size_lat  <= size;
                addr_lat  <= addr;
                wdata_lat <= wdata;
            end
            if (do_access) begin
                rdata <= resp_word;
                err   <= misaligned;
            end
        end
    end

    // Array is deliberately outside the reset domain; contents survive rst.
    always_ff @(posedge clk) begin
        if (do_access && we_lat && !misaligned) mem[word_idx] <= new_word;
    end

    assign ack  = (state == RESP);
    assign busy = (state != IDLE);
endmodule
